// File: rtl/fsmd_bitscan_n.sv
// Bit-scan FSMD: captures an operand on start, shifts it one bit per clock and
// reports the ones count, zeros count or leading-zero count of the operand.
module fsmd_bitscan_n #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             CLK100MHZ,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] dataA,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    count,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b01,
      S_SCAN = 2'b10,
      S_DONE = 2'b11
   } state_t;

   localparam logic [CW-1:0] LP_WIDTH = CW'(WIDTH);
   localparam logic [CW-1:0] LP_ONE   = CW'(1);

   state_t           r_state, w_state_next;
   logic [WIDTH-1:0] r_shift, w_shift_next;
   logic [1:0]       r_mode, w_mode_next;
   logic [CW-1:0]    r_idx, w_idx_next;
   logic [CW-1:0]    r_count, w_count_next;
   logic             w_idx_end;

   assign w_idx_end = (r_idx == LP_WIDTH);

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_mode  <= 2'b00;
         r_idx   <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         r_shift <= w_shift_next;
         r_mode  <= w_mode_next;
         r_idx   <= w_idx_next;
         r_count <= w_count_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_shift_next = r_shift;
      w_mode_next  = r_mode;
      w_idx_next   = r_idx;
      w_count_next = r_count;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_shift_next = dataA;
               w_mode_next  = mode;
               w_idx_next   = '0;
               w_count_next = '0;
               w_state_next = S_SCAN;
            end
         end
         S_SCAN: begin
            case (r_mode)
               2'b01: begin
                  if (w_idx_end) begin
                     w_state_next = S_DONE;
                  end else begin
                     w_count_next = r_count + {{(CW-1){1'b0}}, ~r_shift[0]};
                     w_shift_next = r_shift >> 1;
                     w_idx_next   = r_idx + LP_ONE;
                  end
               end
               2'b10: begin
                  if (w_idx_end || r_shift[WIDTH-1]) begin
                     w_state_next = S_DONE;
                  end else begin
                     w_count_next = r_count + LP_ONE;
                     w_shift_next = r_shift << 1;
                     w_idx_next   = r_idx + LP_ONE;
                  end
               end
               default: begin
                  // Ones count stops as soon as no set bits remain.
                  if (r_shift == '0) begin
                     w_state_next = S_DONE;
                  end else begin
                     w_count_next = r_count + {{(CW-1){1'b0}}, r_shift[0]};
                     w_shift_next = r_shift >> 1;
                  end
               end
            endcase
         end
         S_DONE: begin
            if (!start) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign busy  = (r_state == S_SCAN);
   assign done  = (r_state == S_DONE);
   assign count = r_count;
   assign state = r_state;

endmodule

// File: tb/tb_fsmd_bitscan_n.sv
// Bench for fsmd_bitscan_n at WIDTH=8 and WIDTH=16: directed and random operations
// compared against a bit-counting reference model.
module tb_fsmd_bitscan_n;

   logic        clk = 1'b0;
   logic        reset;
   logic        start8, start16;
   logic [1:0]  mode;
   logic [31:0] data;

   logic        busy8, done8, busy16, done16;
   logic [3:0]  count8;
   logic [4:0]  count16;
   logic [1:0]  state8, state16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fsmd_bitscan_n #(.WIDTH(8)) dut8 (
      .CLK100MHZ(clk), .reset(reset), .start(start8), .mode(mode), .dataA(data[7:0]),
      .busy(busy8), .done(done8), .count(count8), .state(state8)
   );

   fsmd_bitscan_n #(.WIDTH(16)) dut16 (
      .CLK100MHZ(clk), .reset(reset), .start(start16), .mode(mode), .dataA(data[15:0]),
      .busy(busy16), .done(done16), .count(count16), .state(state16)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs_busy(input int w);
      return (w == 8) ? 32'(busy8) : 32'(busy16);
   endfunction
   function automatic logic [31:0] obs_done(input int w);
      return (w == 8) ? 32'(done8) : 32'(done16);
   endfunction
   function automatic logic [31:0] obs_count(input int w);
      return (w == 8) ? 32'(count8) : 32'(count16);
   endfunction
   function automatic logic [31:0] obs_state(input int w);
      return (w == 8) ? 32'(state8) : 32'(state16);
   endfunction

   task automatic set_start(input int w, input logic v);
      if (w == 8) start8 = v;
      else        start16 = v;
   endtask

   // Expected result and SCAN-cycle count straight from the operation's definition.
   task automatic model(input int w, input logic [1:0] m, input logic [31:0] a,
                        output int cnt, output int cyc);
      logic [31:0] v;
      int ones, p, lz;
      bit seen;
      v = a & ((32'd1 << w) - 32'd1);
      ones = $countones(v);
      p = 0;
      for (int i = 0; i < w; i++) if (v[i]) p = i + 1;
      lz = 0;
      seen = 0;
      for (int i = w - 1; i >= 0; i--) begin
         if (v[i]) seen = 1;
         if (!seen) lz++;
      end
      case (m)
         2'b01:   begin cnt = w - ones; cyc = w + 1;  end
         2'b10:   begin cnt = lz;       cyc = lz + 1; end
         default: begin cnt = ones;     cyc = p + 1;  end
      endcase
   endtask

   // One full operation: capture, SCAN, DONE held for hold_cycles, release.
   task automatic run_op(input int w, input logic [1:0] m, input logic [31:0] a,
                         input bit disturb, input int hold_cycles);
      int exp_cnt, exp_cyc, cyc, done_ok;
      model(w, m, a, exp_cnt, exp_cyc);
      mode = m;
      data = a;
      set_start(w, 1'b1);
      @(negedge clk);
      check("scan_state", obs_state(w), 32'h2);
      cyc = 0;
      while (obs_busy(w) == 32'h1 && cyc < 200) begin
         check("no_overlap", obs_done(w), 32'h0);
         cyc++;
         if (disturb) begin
            set_start(w, cyc[0] ? 1'b0 : 1'b1);
            data = 32'hFFFF_FFFF;
            mode = 2'b01;
         end
         @(negedge clk);
      end
      set_start(w, 1'b1);
      check("scan_cycles", cyc, exp_cyc);
      check("done_state", obs_state(w), 32'h3);
      check("done_count", obs_count(w), exp_cnt);
      done_ok = 1;
      for (int i = 0; i < hold_cycles; i++) begin
         @(negedge clk);
         if (obs_done(w) != 32'h1 || obs_busy(w) != 32'h0) done_ok = 0;
      end
      if (hold_cycles > 0) check("done_hold", done_ok, 1);
      set_start(w, 1'b0);
      @(negedge clk);
      check("idle_state", obs_state(w), 32'h1);
      check("idle_done", obs_done(w), 32'h0);
      check("idle_count", obs_count(w), exp_cnt);
      $display("op w=%0d mode=%0d data=%0h count=%0d cycles=%0d exp=%0d/%0d",
               w, m, a, obs_count(w), cyc, exp_cnt, exp_cyc);
   endtask

   task automatic mid_reset(input int w);
      mode = 2'b01;
      data = 32'h0000_00F0;
      set_start(w, 1'b1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      set_start(w, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      check("rst_state", obs_state(w), 32'h1);
      check("rst_count", obs_count(w), 32'h0);
      check("rst_busy", obs_busy(w), 32'h0);
      check("rst_done", obs_done(w), 32'h0);
      $display("mid-scan reset w=%0d state=%0h count=%0d", w, obs_state(w), obs_count(w));
   endtask

   initial begin
      reset = 1'b1;
      start8 = 1'b0;
      start16 = 1'b0;
      mode = 2'b00;
      data = 32'h0;
      @(negedge clk);
      @(negedge clk);
      check("reset_state8", 32'(state8), 32'h1);
      check("reset_count8", 32'(count8), 32'h0);
      check("reset_flags8", {busy8, done8}, 32'h0);
      check("reset_state16", 32'(state16), 32'h1);
      reset = 1'b0;
      @(negedge clk);

      run_op(8, 2'b00, 32'hB2, 0, 3);
      run_op(8, 2'b00, 32'h01, 0, 0);
      run_op(8, 2'b00, 32'h00, 0, 0);
      run_op(8, 2'b11, 32'hFF, 0, 0);
      run_op(8, 2'b01, 32'hB2, 0, 0);
      run_op(8, 2'b01, 32'hFF, 0, 0);
      run_op(8, 2'b10, 32'h1F, 0, 0);
      run_op(8, 2'b10, 32'h80, 0, 0);
      run_op(8, 2'b10, 32'h00, 0, 0);
      run_op(8, 2'b00, 32'h5A, 1, 20);
      run_op(8, 2'b10, 32'h06, 1, 0);
      mid_reset(8);
      run_op(8, 2'b00, 32'hB2, 0, 0);

      run_op(16, 2'b00, 32'h8001, 0, 2);
      run_op(16, 2'b01, 32'h8001, 0, 0);
      run_op(16, 2'b10, 32'h8001, 0, 0);
      run_op(16, 2'b10, 32'h0000, 0, 0);
      run_op(16, 2'b10, 32'h0001, 1, 0);
      mid_reset(16);
      run_op(16, 2'b00, 32'h8001, 0, 0);

      for (int i = 0; i < 24; i++) begin
         run_op(8, 2'($urandom_range(0, 3)), $urandom, i[2], $urandom_range(0, 2));
         run_op(16, 2'($urandom_range(0, 3)), $urandom, i[1], $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
